// File: rtl/mem_defs_pkg.sv
// Shared definitions for the MEM-stage data-memory controller:
// access size encodings, controller state encoding, default park address
// and the alignment rule for loads/stores.
package mem_defs_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] PARK_ADDR_DEF = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    MERGE   = 3'd2,
    WR_WAIT = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Bytes are always aligned; halves need addr[0]=0; words (and the
  // illegal size, treated as a word) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory controller (combinational).
// Extracts and extends a sub-word load from a RAM word, and merges
// right-justified store data into a RAM word for read-modify-write.
module mem_lane_align
  import mem_defs_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane selection and zero/sign extension of the load result
  always_comb begin
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_val = sign ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      SZ_HALF: load_val = sign ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      default: load_val = word;
    endcase
  end

  // Replace only the addressed lane of the old word with the store data
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: turns byte/half/word loads and stores
// into word-wide transactions on a multi-cycle RAM, using read-modify-write
// for sub-word stores and stalling the pipeline for the whole access.
// Optional feature macro: MEM_TIMEOUT_EN (bounded RAM waits, mem_bus_err).
module mem_access_ctrl
  import mem_defs_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 5,
  parameter logic [31:0] PARK_ADDR      = PARK_ADDR_DEF,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_align_err,
`ifdef MEM_TIMEOUT_EN
  output logic        mem_bus_err,
`endif
  output logic        ram_cs,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  input  logic        ram_stall
);

  // Out-of-range word indices are simply forwarded; the RAM answers them
  // with zero, so ADDR_WIDTH only needs to be a sane value here.
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("mem_access_ctrl: unsupported ADDR_WIDTH or TIMEOUT_CYCLES");
  end

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        store_q, store_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_word_q, rd_word_d;
  logic [31:0] wr_word_q, wr_word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        align_err_q, align_err_d;
  logic        first_q, first_d;
  logic        complete;
  logic [31:0] lane_word;
  logic [31:0] load_val;
  logic [31:0] merged;

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              bus_err_q, bus_err_d;
  logic              timeout_hit;
`endif

  // The same lane logic serves load extraction straight off the RAM and
  // the merge step, which works on the word captured during the read.
  assign lane_word = (state_q == MERGE) ? rd_word_q : ram_dout;

  mem_lane_align u_lane (
    .word     (lane_word),
    .wdata    (wdata_q),
    .off      (addr_q[1:0]),
    .size     (size_q),
    .sign     (sign_q),
    .load_val (load_val),
    .merged   (merged)
  );

  // RAM-side outputs follow the state; the address is parked whenever no
  // access is in flight so a repeat access to the same word restarts the RAM.
  always_comb begin
    ram_cs        = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    ram_we        = (state_q == WR_WAIT);
    ram_addr      = ram_cs ? {2'b00, addr_q[31:2]} : PARK_ADDR;
    ram_din       = wr_word_q;
    mem_rdata     = rdata_q;
    mem_align_err = align_err_q;
    mem_stall     = mem_req && (state_q != DONE);
`ifdef MEM_TIMEOUT_EN
    mem_bus_err   = bus_err_q;
`endif
  end

  // Next-state logic: the RAM's stall is stale in the first cycle of a wait
  // state (it updates on the falling edge), so completion is only accepted
  // from the second cycle on.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    sign_d      = sign_q;
    store_d     = store_q;
    wdata_d     = wdata_q;
    rd_word_d   = rd_word_q;
    wr_word_d   = wr_word_q;
    rdata_d     = rdata_q;
    align_err_d = 1'b0;
    complete    = !first_q && !ram_stall;
`ifdef MEM_TIMEOUT_EN
    bus_err_d   = 1'b0;
    timeout_hit = (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));
`endif
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          addr_d  = mem_addr;
          size_d  = mem_size;
          sign_d  = mem_sign;
          store_d = mem_we;
          wdata_d = mem_wdata;
          if (is_misaligned(mem_size, mem_addr[1:0])) begin
            align_err_d = 1'b1;
            rdata_d     = 32'd0;
            state_d     = DONE;
          end else if (!mem_we || mem_size == SZ_BYTE || mem_size == SZ_HALF) begin
            state_d = RD_WAIT;
          end else begin
            wr_word_d = mem_wdata;
            state_d   = WR_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (complete) begin
          rd_word_d = ram_dout;
          if (store_q) begin
            state_d = MERGE;
          end else begin
            rdata_d = load_val;
            state_d = DONE;
          end
`ifdef MEM_TIMEOUT_EN
        end else if (timeout_hit) begin
          rdata_d   = 32'd0;
          bus_err_d = 1'b1;
          state_d   = DONE;
`endif
        end
      end
      MERGE: begin
        wr_word_d = merged;
        state_d   = WR_WAIT;
      end
      WR_WAIT: begin
        if (complete) begin
          state_d = DONE;
`ifdef MEM_TIMEOUT_EN
        end else if (timeout_hit) begin
          rdata_d   = 32'd0;
          bus_err_d = 1'b1;
          state_d   = DONE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    first_d = (state_d != state_q);
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d = (state_d == state_q && (state_q == RD_WAIT || state_q == WR_WAIT))
                 ? wait_cnt_q + WAIT_W'(1) : '0;
`endif
  end

  // State and datapath registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 32'd0;
      size_q      <= SZ_BYTE;
      sign_q      <= 1'b0;
      store_q     <= 1'b0;
      wdata_q     <= 32'd0;
      rd_word_q   <= 32'd0;
      wr_word_q   <= 32'd0;
      rdata_q     <= 32'd0;
      align_err_q <= 1'b0;
      first_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      store_q     <= store_d;
      wdata_q     <= wdata_d;
      rd_word_q   <= rd_word_d;
      wr_word_q   <= wr_word_d;
      rdata_q     <= rdata_d;
      align_err_q <= align_err_d;
      first_q     <= first_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a falling-edge RAM model.
// The RAM answers reads after 8 falling edges; writes retire one edge
// earlier since they need no output stage. Timeout checks run only when
// MEM_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;

  localparam logic [31:0] PARK = 32'hFFFF_FFFF;
  localparam int          LAT  = 8;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_align_err;
`ifdef MEM_TIMEOUT_EN
  logic        mem_bus_err;
`endif
  logic        ram_cs;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_stall;

  logic [31:0] ramMem [0:31];
  logic        ramActive;
  int          ramCnt;
  logic        ramHang;

  int          checkCount;
  int          errorCount;
  int          lastStalls;
  logic [31:0] lastRdata;
  logic        lastAlign;
  logic        lastBusErr;
  logic        csEver;
  logic        csTrace   [0:127];
  logic        weTrace   [0:127];
  logic [31:0] addrTrace [0:127];

  mem_access_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_size      (mem_size),
    .mem_sign      (mem_sign),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_stall     (mem_stall),
    .mem_align_err (mem_align_err),
`ifdef MEM_TIMEOUT_EN
    .mem_bus_err   (mem_bus_err),
`endif
    .ram_cs        (ram_cs),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout),
    .ram_stall     (ram_stall)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: starts an access on the first falling edge with ram_cs high,
  // restarts whenever ram_cs drops, and answers out-of-range words with 0
  always @(negedge clk) begin
    if (!ram_cs) begin
      ramActive <= 1'b0;
      ram_stall <= 1'b0;
    end else if (!ramActive) begin
      ramActive <= 1'b1;
      ramCnt    <= ram_we ? LAT - 1 : LAT;
      ram_stall <= 1'b1;
    end else if (ramHang) begin
      ram_stall <= 1'b1;
    end else if (ramCnt > 1) begin
      ramCnt <= ramCnt - 1;
    end else if (ram_stall) begin
      ram_stall <= 1'b0;
      if (ram_we) begin
        if (ram_addr < 32) ramMem[ram_addr[4:0]] <= ram_din;
      end else begin
        ram_dout <= (ram_addr < 32) ? ramMem[ram_addr[4:0]] : 32'd0;
      end
    end
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Presents one request, holds it until the stall drops, and records the
  // per-cycle RAM-side signals (index 0 is the request cycle)
  task applyStimulus(input logic we, input logic [1:0] size, input logic sign,
                     input logic [31:0] addr, input logic [31:0] wdata);
    bit finished;
    @(posedge clk);
    #1;
    mem_req    = 1'b1;
    mem_we     = we;
    mem_size   = size;
    mem_sign   = sign;
    mem_addr   = addr;
    mem_wdata  = wdata;
    lastStalls = 0;
    csEver     = 1'b0;
    lastBusErr = 1'b0;
    finished   = 1'b0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      #1;
      if (cyc < 128) begin
        csTrace[cyc]   = ram_cs;
        weTrace[cyc]   = ram_we;
        addrTrace[cyc] = ram_addr;
      end
      if (ram_cs) csEver = 1'b1;
      if (mem_stall) begin
        lastStalls++;
      end else begin
        finished  = 1'b1;
        lastRdata = mem_rdata;
        lastAlign = mem_align_err;
`ifdef MEM_TIMEOUT_EN
        lastBusErr = mem_bus_err;
`endif
        mem_req = 1'b0;
      end
      if (!finished) begin
        @(posedge clk);
        #1;
      end
    end
    if (!finished) checkOutput("access_completes", 32'd0, 32'd1);
    mem_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    ramHang    = 1'b0;
    ramActive  = 1'b0;
    ramCnt     = 0;
    ram_stall  = 1'b0;
    ram_dout   = 32'd0;
    for (int i = 0; i < 32; i++) ramMem[i] = 32'd0;
    ramMem[3]  = 32'h8899_AABB;
    ramMem[6]  = 32'h1234_5678;
    rst        = 1'b1;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_size   = 2'b00;
    mem_sign   = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_ram_cs",    {31'd0, ram_cs},        32'd0);
    checkOutput("rst_ram_we",    {31'd0, ram_we},        32'd0);
    checkOutput("rst_ram_addr",  ram_addr,               PARK);
    checkOutput("rst_ram_din",   ram_din,                32'd0);
    checkOutput("rst_rdata",     mem_rdata,              32'd0);
    checkOutput("rst_align_err", {31'd0, mem_align_err}, 32'd0);
    checkOutput("rst_stall",     {31'd0, mem_stall},     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Word load of word 3
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'd0);
    checkOutput("wload_stalls",     lastStalls,          LAT + 2);
    checkOutput("wload_rdata",      lastRdata,           32'h8899_AABB);
    checkOutput("wload_addr_first", addrTrace[1],        32'd3);
    checkOutput("wload_addr_last",  addrTrace[LAT + 1],  32'd3);
    checkOutput("wload_cs",         {31'd0, csTrace[1]}, 32'd1);
    checkOutput("wload_no_align",   {31'd0, lastAlign},  32'd0);

    // Sub-word loads: lanes, zero and sign extension
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_000D, 32'd0);
    checkOutput("lb_signed",   lastRdata, 32'hFFFF_FFAA);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_000E, 32'd0);
    checkOutput("lhu",         lastRdata, 32'h0000_8899);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_000E, 32'd0);
    checkOutput("lh_signed",   lastRdata, 32'hFFFF_8899);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_000F, 32'd0);
    checkOutput("lbu_lane3",   lastRdata, 32'h0000_0088);
    checkOutput("rdata_holds", mem_rdata, 32'h0000_0088);

    // Byte store: read, merge (RAM deselected), write
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_000D, 32'h0000_0011);
    checkOutput("sb_stalls",      lastStalls,                   2 * LAT + 3);
    checkOutput("sb_mem",         ramMem[3],                    32'h8899_11BB);
    checkOutput("sb_rd_we_low",   {31'd0, weTrace[LAT + 1]},    32'd0);
    checkOutput("sb_merge_cs",    {31'd0, csTrace[LAT + 2]},    32'd0);
    checkOutput("sb_merge_addr",  addrTrace[LAT + 2],           PARK);
    checkOutput("sb_wr_we",       {31'd0, weTrace[LAT + 3]},    32'd1);
    checkOutput("sb_wr_addr",     addrTrace[LAT + 3],           32'd3);
    checkOutput("sb_rdata_keeps", lastRdata,                    32'h0000_0088);

    // Back-to-back word loads of the same word each pay the full latency
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'd0);
    checkOutput("b2b1_stalls",    lastStalls,                32'(LAT + 2));
    checkOutput("b2b1_rdata",     lastRdata,                 32'h8899_11BB);
    checkOutput("b2b1_done_addr", addrTrace[LAT + 2],        PARK);
    checkOutput("b2b1_done_cs",   {31'd0, csTrace[LAT + 2]}, 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'd0);
    checkOutput("b2b2_stalls",    lastStalls,                32'(LAT + 2));
    checkOutput("b2b2_rdata",     lastRdata,                 32'h8899_11BB);

    // Upper-half store into a zero word
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h1234_CAFE);
    checkOutput("sh_stalls", lastStalls, 2 * LAT + 3);
    checkOutput("sh_mem",    ramMem[4],  32'hCAFE_0000);

    // Word store goes straight to the write, then read back via illegal size
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0014, 32'hDEAD_BEEF);
    checkOutput("sw_mem",    ramMem[5],           32'hDEAD_BEEF);
    checkOutput("sw_we",     {31'd0, weTrace[1]}, 32'd1);
    checkOutput("sw_addr",   addrTrace[1],        32'd5);
    applyStimulus(1'b0, 2'b11, 1'b1, 32'h0000_0014, 32'd0);
    checkOutput("size11_as_word", lastRdata, 32'hDEAD_BEEF);

    // Misaligned accesses never touch the RAM
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'd0);
    checkOutput("mis_h_stalls", lastStalls,         32'd1);
    checkOutput("mis_h_align",  {31'd0, lastAlign}, 32'd1);
    checkOutput("mis_h_cs",     {31'd0, csEver},    32'd0);
    checkOutput("mis_h_rdata",  lastRdata,          32'd0);
    checkOutput("align_pulse",  {31'd0, mem_align_err}, 32'd0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0016, 32'hFFFF_FFFF);
    checkOutput("mis_w_align",  {31'd0, lastAlign}, 32'd1);
    checkOutput("mis_w_mem",    ramMem[5],          32'hDEAD_BEEF);

    // Out-of-range word index is forwarded; RAM answers zero
    ramMem[0] = 32'hA5A5_A5A5;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'd0);
    checkOutput("oor_addr",  addrTrace[1], 32'd32);
    checkOutput("oor_rdata", lastRdata,    32'd0);

    // Reset during the fourth write-wait cycle abandons the write
    @(posedge clk);
    #1;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_size  = 2'b10;
    mem_sign  = 1'b0;
    mem_addr  = 32'h0000_0018;
    mem_wdata = 32'h0000_0055;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("pre_rst_we", {31'd0, ram_we}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_cs",    {31'd0, ram_cs},    32'd0);
    checkOutput("midrst_we",    {31'd0, ram_we},    32'd0);
    checkOutput("midrst_addr",  ram_addr,           PARK);
    checkOutput("midrst_stall", {31'd0, mem_stall}, 32'd1);
    checkOutput("midrst_rdata", mem_rdata,          32'd0);
    mem_req = 1'b0;
    #1;
    checkOutput("midrst_noreq", {31'd0, mem_stall}, 32'd0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("midrst_nowrite", ramMem[6], 32'h1234_5678);
    checkOutput("midrst_idle_cs", {31'd0, ram_cs}, 32'd0);

`ifdef MEM_TIMEOUT_EN
    // A RAM that never finishes is cut off after the wait limit
    ramHang = 1'b1;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'd0);
    checkOutput("to_stalls",  lastStalls,          32'd65);
    checkOutput("to_bus_err", {31'd0, lastBusErr}, 32'd1);
    checkOutput("to_rdata",   lastRdata,           32'd0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_000C, 32'h0000_0077);
    checkOutput("to_sb_nowrite", ramMem[3], 32'h8899_11BB);
    ramHang = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
